uart_rx: RTL and testbench

- Synthesizable UART receiver (8N1, LSB first), the peer of the SoC's UART transmitter on the `TX` line.
- Used in the board-level loopback fixture and for verification-harness capture of SoC console output.
- Recovers bytes from a serial line by mid-bit sampling against a cycle counter.
- Presents each received byte through a one-entry valid/ready holding register, with framing-error and overrun flags.

---
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling against a down-counter,
// one-entry valid/ready holding register, framing and overrun pulses.
module uart_rx #(
  parameter int clk_freq = 32000000,
  parameter int baudrate = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CPB  = clk_freq / baudrate;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);

  generate
    if (CPB < 4) begin : g_cpb_chk
      $error("uart_rx: clk_freq/baudrate must be >= 4");
    end
  endgenerate

  localparam logic [CW-1:0] C_FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] C_HALF = CW'(HALF - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAITH = 3'd4;

  logic [2:0]    r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shreg;

  logic w_rx_s;
  logic w_tick;
  logic w_xfer;

  assign w_rx_s = r_sync2;
  assign w_tick = (r_cnt == '0);
  assign w_xfer = rx_valid & rx_ready;
  assign busy   = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shreg   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // a load in the STOP branch below overrides this clear
      if (w_xfer) begin
        rx_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_cnt   <= C_HALF;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (!w_rx_s) begin
              r_cnt   <= C_FULL;
              r_idx   <= '0;
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shreg <= {w_rx_s, r_shreg[7:1]};
            r_cnt   <= C_FULL;
            r_idx   <= r_idx + 1'b1;
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (w_rx_s) begin
              r_state <= S_IDLE;
              if (!rx_valid || w_xfer) begin
                rx_data  <= r_shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              r_state   <= S_WAITH;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WAITH: begin
          if (w_rx_s) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames
// checked against a frame-level expectation queue.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = 8;
  localparam int LAT  = 3 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(
    .clk_freq(16),
    .baudrate(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int         cyc = 0;
  int         rise_cyc = -1;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         busy_cnt = 0;
  logic       prev_v = 1'b0;
  logic [7:0] obs[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && !prev_v) rise_cyc = cyc;
      if (rx_valid && rx_ready) obs.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (busy) busy_cnt++;
      if (frame_err && overrun)
        check("flags_excl", 32'(frame_err & overrun), 0);
      prev_v = rx_valid;
    end else begin
      prev_v = 1'b0;
    end
  end

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stp);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(stp, CPB);
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (!rx_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!rx_valid) check("valid_timeout", 0, 1);
  endtask

  logic [7:0] exp_q[$];
  int         t0;
  int         base;
  int         fe0;
  int         ov0;
  int         nb;
  logic [7:0] b;
  logic       bad;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_data", 32'(rx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_flags", 32'({frame_err, overrun}), 0);
    reset = 1'b0;

    // idle line
    rx_ready = 1'b1;
    repeat (500) @(negedge clk);
    check("idle_obs", 32'(obs.size()), 0);
    check("idle_busy", 32'(busy_cnt), 0);
    check("idle_flags", 32'(fe_cnt + ov_cnt), 0);
    check("idle_data", 32'(rx_data), 0);

    // single byte, consumer stalled
    rx_ready = 1'b0;
    t0 = cyc;
    send_frame(8'h55, 1'b1);
    wait_valid(40);
    check("lat_ok",
          32'((rise_cyc - t0 >= LAT - 1) &&
              (rise_cyc - t0 <= LAT + 1)), 1);
    check("b55_data", 32'(rx_data), 32'h55);
    check("b55_busy", 32'(busy), 0);
    repeat (5) @(negedge clk);
    check("b55_hold", 32'(rx_valid), 1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("b55_clr", 32'(rx_valid), 0);

    // back-to-back, no gap
    rx_ready = 1'b1;
    base = obs.size();
    ov0 = ov_cnt;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b_n", 32'(obs.size() - base), 2);
    if (obs.size() - base == 2) begin
      check("b2b_0", 32'(obs[base]), 32'hA5);
      check("b2b_1", 32'(obs[base+1]), 32'h3C);
    end
    check("b2b_ov", 32'(ov_cnt - ov0), 0);

    // start glitch
    base = obs.size();
    fe0 = fe_cnt;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 40);
    check("gl_obs", 32'(obs.size() - base), 0);
    check("gl_fe", 32'(fe_cnt - fe0), 0);
    check("gl_busy", 32'(busy), 0);

    // framing error then recovery
    base = obs.size();
    fe0 = fe_cnt;
    send_frame(8'h81, 1'b0);
    drive_bit(1'b0, 40);
    drive_bit(1'b1, 8);
    check("fe_cnt", 32'(fe_cnt - fe0), 1);
    check("fe_obs", 32'(obs.size() - base), 0);
    send_frame(8'h7E, 1'b1);
    repeat (10) @(negedge clk);
    check("fe_rec_n", 32'(obs.size() - base), 1);
    if (obs.size() - base == 1)
      check("fe_rec_d", 32'(obs[base]), 32'h7E);

    // overrun
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (10) @(negedge clk);
    check("ov_cnt", 32'(ov_cnt - ov0), 1);
    check("ov_data", 32'(rx_data), 32'h11);
    check("ov_valid", 32'(rx_valid), 1);

    // reset mid-frame
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b0, 5);
    check("mid_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check("ar_valid", 32'(rx_valid), 0);
    check("ar_data", 32'(rx_data), 0);
    check("ar_busy", 32'(busy), 0);
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    rx_ready = 1'b1;
    base = obs.size();
    send_frame(8'h33, 1'b1);
    repeat (10) @(negedge clk);
    check("ar_rec_n", 32'(obs.size() - base), 1);
    if (obs.size() - base == 1)
      check("ar_rec_d", 32'(obs[base]), 32'h33);

    // random frames against expectation queue
    base = obs.size();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      b = 8'($urandom);
      bad = ($urandom_range(5) == 0);
      send_frame(b, ~bad);
      if (bad) begin
        nb++;
        drive_bit(1'b0, $urandom_range(30));
        drive_bit(1'b1, CPB);
      end else begin
        exp_q.push_back(b);
        drive_bit(1'b1, CPB * $urandom_range(3));
      end
    end
    repeat (3 * CPB) @(negedge clk);
    check("rnd_n", 32'(obs.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < obs.size())
        check($sformatf("rnd_%0d", i), 32'(obs[base+i]), 32'(exp_q[i]));
    end
    check("rnd_fe", 32'(fe_cnt - fe0), 32'(nb));
    check("rnd_ov", 32'(ov_cnt - ov0), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
